ckpt_spec_free_list: RTL
========================

// Module: ckpt_spec_free_list
// PURPOSE
//  N-wide speculative physical-register free list for the rename stage, generalised in rename width,
//  commit width, physical register file size and checkpoint count. Adds per-branch checkpoints
//  (single-cycle restore of the allocation head) on top of full commit-point recovery.
//  Sits between the rename-map table (consumer) and the active list (commit/free producer).
// PARAMETERS
//  PHYS_REGS  96  physical registers; ids LOG_REGS..PHYS_REGS-1 start free; D = PHYS_REGS-LOG_REGS
//  LOG_REGS   34  logical registers; ids 0..LOG_REGS-1 start mapped, never in the list at reset
//  ALLOC_W    4   allocation lanes per cycle (dispatch width)
//  FREE_W     4   freed-register lanes per cycle (commit width)
//  N_CKPT     4   checkpoint slots; CK_W = $clog2(N_CKPT), P_W = $clog2(PHYS_REGS)
// PORTS
//  clk            in   1              clock
//  reset          in   1              asynchronous, active-high reset
//  reqPhyReg_i    in   ALLOC_W        per-lane allocation request
//  freePhyReg_o   out  ALLOC_W*P_W    allocated id per lane (valid only if lane requested and !empty)
//  freeListEmpty_o out 1              popcount(reqPhyReg_i) > count; no allocation this cycle
//  freedValid_i   in   FREE_W         per-lane freed-register valid
//  freedPhyReg_i  in   FREE_W*P_W     freed ids, pushed at tail
//  commitCnt_i    in   $clog2(ALLOC_W*2)+1  allocations retired this cycle (advances commit head)
//  recoverFlag_i  in   1              full flush: head <= commit head
//  ckptTake_i     in   1              snapshot head into slot ckptId_o
//  ckptId_o       out  CK_W           lowest-index free checkpoint slot
//  ckptFull_o     out  1              all N_CKPT slots valid; take ignored
//  ckptRestore_i  in   1              restore to slot ckptRestoreId_i
//  ckptRelease_i  in   1              invalidate slot ckptRestoreId_i (branch resolved correct)
//  ckptRestoreId_i in  CK_W           slot for restore/release
//  freeCnt_o      out  $clog2(D+1)    current free count (perf/debug)
//  overflow_o     out  1              sticky: push would exceed D
// BEHAVIOUR
//  - State: entry[0..D-1] (P_W each), head, cmtHead, tail (mod D), count, specOut, per-slot
//    ckptHead, ckptDist (allocs since take), ckptValid.
//  - Reset (async): entry[i]=LOG_REGS+i; head=cmtHead=tail=0; count=D; specOut=0; ckptValid=0;
//    overflow_o=0; freeListEmpty_o=0 when no request; freePhyReg_o = entry[0..] (don't-care lanes).
//  - Allocation, 0-cycle: lanes compacted in order; k-th set request bit gets entry[(head+k)%D].
//    All-or-nothing: if nReq > count, freeListEmpty_o=1, head/count unchanged.
//    Else head += nReq (mod D, non-power-of-2 wrap by compare-subtract).
//  - Free: valid lanes compacted in order to entry[(tail+k)%D]; tail += nFreed. Visible to
//    allocation next cycle (no same-cycle bypass). count+nFreed-nAlloc > D -> overflow_o=1, push dropped.
//  - Commit: cmtHead += commitCnt_i; specOut += nAlloc - commitCnt_i.
//  - Priority per cycle: reset > recover > restore > release/take/alloc.
//  - recoverFlag_i: head<=cmtHead; count<=count+specOut+nFreed; specOut<=0; ckptValid<=0;
//    allocation and take suppressed (freePhyReg_o still driven, requester must not consume).
//  - Restore slot c (valid): head<=ckptHead[c]; count<=count+ckptDist[c]+nFreed;
//    specOut-=ckptDist[c]; invalidate c and every slot with ckptDist < ckptDist[c];
//    surviving slots: ckptDist -= ckptDist[c]. Alloc and take suppressed. Restore of invalid slot ignored.
//  - Take: slot ckptId_o gets ckptHead = head AFTER this cycle's allocation, ckptDist=0, valid=1.
//  - Every valid slot: ckptDist += nAlloc each non-suppressed cycle. Release clears valid only;
//    take and release of same slot in one cycle -> release applied first, take may reuse it.
// TESTING
//  - Reset, req=4'b1111 -> ids 34,35,36,37; count 62->58; next cycle req=4'b0101 -> lane0=38, lane2=39.
//  - Drain to count=2, req=4'b0111 -> freeListEmpty_o=1, head unchanged; free 1 id -> next cycle grants.
//  - Take ckpt at head=8, allocate 3x4 regs, restore -> head=8, count +12, next alloc re-issues same ids.
//  - Take slots 0,1,2 across allocations; restore slot 1 -> slots 1,2 invalid, slot 0 dist reduced.
//  - Wrap: head=D-2, req 4 lanes -> ids entry[60],[61],[0],[1]; tail wrap with 4 frees likewise.
//  - recover with specOut=10, same-cycle 2 frees -> count += 12, all ckpts invalid; reset mid-flush -> reset state.

Source files
------------

// File: rtl/ckpt_spec_free_list.sv
// Speculative N-wide physical-register free list for rename, with per-branch checkpoints
// (single-cycle head restore) and full commit-point recovery.
module ckpt_spec_free_list #(
    parameter int unsigned PHYS_REGS = 96,
    parameter int unsigned LOG_REGS  = 34,
    parameter int unsigned ALLOC_W   = 4,
    parameter int unsigned FREE_W    = 4,
    parameter int unsigned N_CKPT    = 4,
    localparam int unsigned D        = PHYS_REGS - LOG_REGS,
    localparam int unsigned P_W      = $clog2(PHYS_REGS),
    localparam int unsigned CK_W     = $clog2(N_CKPT),
    localparam int unsigned CC_W     = $clog2(ALLOC_W * 2) + 1,
    localparam int unsigned FC_W     = $clog2(D + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ALLOC_W-1:0]       reqPhyReg_i,
    output logic [ALLOC_W*P_W-1:0]   freePhyReg_o,
    output logic                     freeListEmpty_o,
    input  logic [FREE_W-1:0]        freedValid_i,
    input  logic [FREE_W*P_W-1:0]    freedPhyReg_i,
    input  logic [CC_W-1:0]          commitCnt_i,
    input  logic                     recoverFlag_i,
    input  logic                     ckptTake_i,
    output logic [CK_W-1:0]          ckptId_o,
    output logic                     ckptFull_o,
    input  logic                     ckptRestore_i,
    input  logic                     ckptRelease_i,
    input  logic [CK_W-1:0]          ckptRestoreId_i,
    output logic [FC_W-1:0]          freeCnt_o,
    output logic                     overflow_o
);

    localparam int unsigned IW = $clog2(D);
    // Headroom so count + specOut + nFreed never wraps before the overflow compare.
    localparam int unsigned CW = FC_W + 2;

    logic [P_W-1:0]    entry_q [D];
    logic [P_W-1:0]    entry_d [D];
    logic [IW-1:0]     head_q, head_d, cmt_head_q, cmt_head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d, spec_q, spec_d;
    logic              overflow_q, overflow_d;
    logic [N_CKPT-1:0] ck_valid_q, ck_valid_d;
    logic [IW-1:0]     ck_head_q [N_CKPT];
    logic [IW-1:0]     ck_head_d [N_CKPT];
    logic [CW-1:0]     ck_dist_q [N_CKPT];
    logic [CW-1:0]     ck_dist_d [N_CKPT];

    logic [CW-1:0]     n_req, n_freed, n_alloc, base_cnt, rst_dist;
    logic              empty_c, rid_ok, restore_hit, suppress, push_ok;
    logic [N_CKPT-1:0] rel_mask, valid_rel;
    logic [CK_W-1:0]   ckpt_id_c;
    logic              ckpt_full_c;
    logic [IW-1:0]     lane_off;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [IW-1:0] inc);
        logic [IW:0] s;
        s = {1'b0, base} + {1'b0, inc};
        if (s >= (IW+1)'(D)) s = s - (IW+1)'(D);
        return s[IW-1:0];
    endfunction

    assign rid_ok = ({1'b0, ckptRestoreId_i} < (CK_W+1)'(N_CKPT));

    // Request/free popcounts and the cycle's allocation decision.
    always_comb begin
        n_req   = '0;
        n_freed = '0;
        for (int i = 0; i < ALLOC_W; i++) n_req = n_req + CW'(reqPhyReg_i[i]);
        for (int i = 0; i < FREE_W; i++) n_freed = n_freed + CW'(freedValid_i[i]);
        empty_c     = n_req > count_q;
        restore_hit = ckptRestore_i && !recoverFlag_i && rid_ok && ck_valid_q[ckptRestoreId_i];
        suppress    = recoverFlag_i || restore_hit;
        n_alloc     = (!empty_c && !suppress) ? n_req : '0;
        rst_dist    = ck_dist_q[ckptRestoreId_i];
    end

    // Requesting lanes are compacted: the k-th set bit reads entry[head+k].
    always_comb begin
        freePhyReg_o = '0;
        lane_off     = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            freePhyReg_o[i*P_W +: P_W] = entry_q[wrap_add(head_q, lane_off)];
            if (reqPhyReg_i[i]) lane_off = lane_off + IW'(1);
        end
    end

    // Head, commit head, count and speculative-outstanding bookkeeping.
    always_comb begin
        head_d     = head_q;
        cmt_head_d = wrap_add(cmt_head_q, IW'(commitCnt_i));
        spec_d     = spec_q;
        base_cnt   = count_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        push_ok    = 1'b0;
        if (recoverFlag_i) begin
            head_d   = cmt_head_d;
            base_cnt = count_q + spec_q - CW'(commitCnt_i);
            spec_d   = '0;
        end else if (restore_hit) begin
            head_d   = ck_head_q[ckptRestoreId_i];
            base_cnt = count_q + rst_dist;
            spec_d   = spec_q - rst_dist - CW'(commitCnt_i);
        end else begin
            head_d   = wrap_add(head_q, IW'(n_alloc));
            base_cnt = count_q - n_alloc;
            spec_d   = spec_q + n_alloc - CW'(commitCnt_i);
        end
        if (base_cnt + n_freed > CW'(D)) begin
            overflow_d = 1'b1;
            count_d    = base_cnt;
        end else begin
            push_ok = 1'b1;
            count_d = base_cnt + n_freed;
        end
    end

    // Freed ids are compacted onto the tail; the whole push is dropped on overflow.
    always_comb begin
        entry_d = entry_q;
        tail_d  = tail_q;
        if (push_ok) begin
            for (int i = 0; i < FREE_W; i++) begin
                if (freedValid_i[i]) begin
                    entry_d[tail_d] = freedPhyReg_i[i*P_W +: P_W];
                    tail_d          = wrap_add(tail_d, IW'(1));
                end
            end
        end
    end

    // Checkpoint slots: release frees a slot before take picks the lowest free one.
    always_comb begin
        ck_valid_d = ck_valid_q;
        ck_head_d  = ck_head_q;
        ck_dist_d  = ck_dist_q;
        rel_mask   = '0;
        if (ckptRelease_i && !suppress && rid_ok) rel_mask[ckptRestoreId_i] = 1'b1;
        valid_rel   = ck_valid_q & ~rel_mask;
        ckpt_full_c = &valid_rel;
        ckpt_id_c   = '0;
        for (int j = N_CKPT - 1; j >= 0; j--) begin
            if (!valid_rel[j]) ckpt_id_c = CK_W'(j);
        end
        if (recoverFlag_i) begin
            ck_valid_d = '0;
        end else if (restore_hit) begin
            // Younger checkpoints (smaller distance) die with the restored one.
            for (int j = 0; j < N_CKPT; j++) begin
                if (ck_valid_q[j] && CK_W'(j) != ckptRestoreId_i && ck_dist_q[j] >= rst_dist)
                    ck_dist_d[j] = ck_dist_q[j] - rst_dist;
                else
                    ck_valid_d[j] = 1'b0;
            end
        end else begin
            ck_valid_d = valid_rel;
            for (int j = 0; j < N_CKPT; j++) begin
                if (valid_rel[j]) ck_dist_d[j] = ck_dist_q[j] + n_alloc;
            end
            if (ckptTake_i && !ckpt_full_c) begin
                ck_valid_d[ckpt_id_c] = 1'b1;
                ck_head_d[ckpt_id_c]  = head_d;
                ck_dist_d[ckpt_id_c]  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < D; i++) entry_q[i] <= P_W'(LOG_REGS + i);
            head_q     <= '0;
            cmt_head_q <= '0;
            tail_q     <= '0;
            count_q    <= CW'(D);
            spec_q     <= '0;
            overflow_q <= 1'b0;
            ck_valid_q <= '0;
            for (int j = 0; j < N_CKPT; j++) begin
                ck_head_q[j] <= '0;
                ck_dist_q[j] <= '0;
            end
        end else begin
            entry_q    <= entry_d;
            head_q     <= head_d;
            cmt_head_q <= cmt_head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            spec_q     <= spec_d;
            overflow_q <= overflow_d;
            ck_valid_q <= ck_valid_d;
            ck_head_q  <= ck_head_d;
            ck_dist_q  <= ck_dist_d;
        end
    end

    assign freeListEmpty_o = empty_c;
    assign ckptId_o        = ckpt_id_c;
    assign ckptFull_o      = ckpt_full_c;
    assign freeCnt_o       = FC_W'(count_q);
    assign overflow_o      = overflow_q;

endmodule
